// File: rtl/chia_xung_pkg.sv
// Shared types and default constants for the chia_xung clock-divider slice.
package chia_xung_pkg;

  localparam int unsigned CNT_W    = 26;
  localparam int unsigned DEF_HALF = 25000000;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_e;

endpackage

// File: rtl/chia_xung_cnt.sv
// Loadable wrap counter: counts 0..limit-1 while enabled, flags the wrap cycle.
module chia_xung_cnt #(
  parameter int unsigned CNT_W = 26
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic [CNT_W-1:0] cnt,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign wrap = en && (cnt_q == limit - CNT_W'(1));
  assign cnt  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr || wrap) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/chia_xung_ctrl.sv
// Square-wave divider: run/drain FSM, half-period config handshake, q/tick registers.
module chia_xung_ctrl
  import chia_xung_pkg::*;
#(
  parameter int unsigned CNT_W    = chia_xung_pkg::CNT_W,
  parameter int unsigned DEF_HALF = chia_xung_pkg::DEF_HALF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_half,
  output logic             cfg_ready,
  output logic             cfg_err,
  output logic             q,
  output logic             tick,
  output logic             busy
);

  state_e           state_q, state_d;
  logic             q_q, q_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic             pend_v_q, pend_v_d;
  logic [CNT_W-1:0] pend_h_q, pend_h_d;

  logic             cnt_en;
  logic             cnt_clr;
  logic             wrap;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             cfg_zero;

  // In DRAIN with q low the period is abandoned, unless en comes back first.
  assign cnt_en  = (state_q == RUN) || ((state_q == DRAIN) && (en || q_q));
  assign cnt_clr = (state_d == IDLE);

  chia_xung_cnt #(.CNT_W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .limit (half_q),
    .cnt   (cnt),
    .wrap  (wrap)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en) begin
          state_d = RUN;
        end else if (!q_q || wrap) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept   = cfg_valid && cfg_ready;
  assign cfg_zero = (cfg_half == '0);

  always_comb begin
    q_d      = wrap ? !q_q : q_q;
    tick_d   = wrap && !q_q;
    err_d    = accept && cfg_zero;
    half_d   = half_q;
    pend_v_d = pend_v_q;
    pend_h_d = pend_h_q;
    // Pending value lands at a wrap or whenever the FSM is (or is becoming) idle.
    if (pend_v_q && (wrap || state_q == IDLE || state_d == IDLE)) begin
      half_d   = pend_h_q;
      pend_v_d = 1'b0;
    end
    if (accept && !cfg_zero) begin
      if (state_q == IDLE) begin
        half_d = cfg_half;
      end else begin
        pend_v_d = 1'b1;
        pend_h_d = cfg_half;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      q_q      <= 1'b0;
      tick_q   <= 1'b0;
      err_q    <= 1'b0;
      half_q   <= CNT_W'(DEF_HALF);
      pend_v_q <= 1'b0;
      pend_h_q <= '0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      tick_q   <= tick_d;
      err_q    <= err_d;
      half_q   <= half_d;
      pend_v_q <= pend_v_d;
      pend_h_q <= pend_h_d;
    end
  end

  assign cfg_ready = !pend_v_q;
  assign cfg_err   = err_q;
  assign q         = q_q;
  assign tick      = tick_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_chia_xung_ctrl.sv
// Directed bench for chia_xung_ctrl with a countdown-style reference model.
module tb_chia_xung_ctrl;

  localparam int unsigned W = 26;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_half;
  logic         cfg_ready, cfg_err, q, tick, busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit started = 1'b0;

  chia_xung_ctrl #(.CNT_W(W), .DEF_HALF(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_half  (cfg_half),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .q         (q),
    .tick      (tick),
    .busy      (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: mode 0=idle 1=run 2=drain; left = cycles remaining in the current half phase.
  int m_mode = 0, m_left = 0, m_half = 4, m_pval = 0;
  bit m_q = 0, m_tick = 0, m_err = 0, m_pv = 0;

  always @(posedge clk) begin
    int nmode;
    bit counting, wrapped, acc, q_old;
    if (!rst_n) begin
      started = 1'b1;
      m_mode = 0; m_left = 0; m_half = 4; m_pv = 0;
      m_q = 0; m_tick = 0; m_err = 0;
    end else begin
      q_old    = m_q;
      acc      = cfg_valid && !m_pv;
      counting = (m_mode == 1) || (m_mode == 2 && (en || q_old));
      wrapped  = counting && (m_left == 1);
      m_tick   = wrapped && !q_old;
      m_err    = acc && (cfg_half == 0);
      if (counting && !wrapped) m_left = m_left - 1;
      if (wrapped) m_q = !q_old;
      if (en) nmode = 1;
      else if (m_mode == 0) nmode = 0;
      else if (m_mode == 1) nmode = 2;
      else nmode = (!q_old || wrapped) ? 0 : 2;
      if (m_pv && (wrapped || m_mode == 0 || nmode == 0)) begin
        m_half = m_pval;
        m_pv = 0;
      end
      if (acc && cfg_half != 0) begin
        if (m_mode == 0) m_half = int'(cfg_half);
        else begin
          m_pv = 1;
          m_pval = int'(cfg_half);
        end
      end
      if (wrapped || (m_mode == 0 && nmode == 1)) m_left = m_half;
      m_mode = nmode;
    end
    #1;
    if (started) begin
      chk("model_q", q, m_q);
      chk("model_tick", tick, m_tick);
      chk("model_cfg_err", cfg_err, m_err);
      chk("model_cfg_ready", cfg_ready, !m_pv);
      chk("model_busy", busy, m_mode != 0);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_tick(output int c);
    int n = 0;
    do begin
      @(posedge clk); #1; n++;
    end while (tick !== 1'b1 && n < 100);
    if (tick !== 1'b1) chk("tick_timeout", 0, 1);
    c = cyc;
  endtask

  task automatic wait_q_low(output int c);
    int n = 0;
    while (q !== 1'b0 && n < 100) begin
      @(posedge clk); #1; n++;
    end
    if (q !== 1'b0) chk("q_low_timeout", 0, 1);
    c = cyc;
  endtask

  initial begin
    int c0, t1, t2, t3;
    rst_n = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_half = '0;
    do_reset();
    chk("reset_q", q, 0);
    chk("reset_busy", busy, 0);
    chk("reset_ready", cfg_ready, 1);
    chk("reset_tick", tick, 0);

    // Default half of 4: rise 4 RUN cycles after entry, period 8.
    @(negedge clk); en = 1'b1; c0 = cyc;
    wait_tick(t1); chk("s1_first_rise", t1 - c0, 5);
    chk("s1_busy", busy, 1);
    wait_tick(t2); chk("s1_period_a", t2 - t1, 8);
    wait_tick(t3); chk("s1_period_b", t3 - t2, 8);

    // Drop en just after a rise: the high phase completes, then idle.
    @(negedge clk); en = 1'b0; c0 = cyc;
    wait_q_low(t1); chk("drain_fall", t1 - c0, 4);
    chk("drain_busy", busy, 0);

    // Re-assert en during DRAIN: no gap in the waveform.
    @(negedge clk); en = 1'b1;
    wait_tick(t1);
    @(negedge clk); en = 1'b0;
    @(negedge clk);
    @(negedge clk); en = 1'b1;
    wait_tick(t2); chk("drain_nogap", t2 - t1, 8);
    @(negedge clk); en = 1'b0;
    wait_q_low(t1);
    @(negedge clk);

    // Config of 2 while idle.
    @(negedge clk); cfg_valid = 1'b1; cfg_half = W'(2);
    @(negedge clk); cfg_valid = 1'b0; en = 1'b1; c0 = cyc;
    chk("s2_ready", cfg_ready, 1);
    wait_tick(t1); chk("s2_first_rise", t1 - c0, 3);
    wait_tick(t2); chk("s2_period", t2 - t1, 4);
    @(negedge clk); en = 1'b0;
    wait_q_low(t1);
    @(negedge clk);

    // Half of 1 loaded on the same edge as RUN entry.
    @(negedge clk); cfg_valid = 1'b1; cfg_half = W'(1); en = 1'b1; c0 = cyc;
    @(negedge clk); cfg_valid = 1'b0;
    wait_tick(t1); chk("h1_first_rise", t1 - c0, 2);
    wait_tick(t2); chk("h1_period", t2 - t1, 2);
    @(negedge clk); en = 1'b0;
    wait_q_low(t1);

    // Mid-phase config of 6 in RUN.
    do_reset();
    en = 1'b1;
    wait_tick(t1);
    @(negedge clk);
    @(negedge clk); cfg_valid = 1'b1; cfg_half = W'(6);
    @(negedge clk); cfg_valid = 1'b0;
    chk("s3_ready_low", cfg_ready, 0);
    wait_tick(t2); chk("s3_transition", t2 - t1, 10);
    chk("s3_ready_back", cfg_ready, 1);
    wait_tick(t3); chk("s3_period", t3 - t2, 12);

    // Accept on a wrap edge: new half applies at the following wrap.
    repeat (6) @(negedge clk);
    cfg_valid = 1'b1; cfg_half = W'(4);
    @(negedge clk); cfg_valid = 1'b0;
    wait_tick(t1); chk("wrap_acc_old", t1 - t3, 12);
    wait_tick(t2); chk("wrap_acc_new", t2 - t1, 8);

    // Zero half: error pulse, no change.
    @(negedge clk); cfg_valid = 1'b1; cfg_half = '0;
    @(negedge clk); cfg_valid = 1'b0;
    chk("s4_err", cfg_err, 1);
    chk("s4_ready", cfg_ready, 1);
    @(negedge clk);
    chk("s4_err_clear", cfg_err, 0);
    wait_tick(t1);
    wait_tick(t2); chk("s4_period", t2 - t1, 8);

    // Reset mid-high-phase with a pending config.
    wait_tick(t1);
    @(negedge clk); cfg_valid = 1'b1; cfg_half = W'(6);
    @(negedge clk); cfg_valid = 1'b1; cfg_half = W'(2); rst_n = 1'b0;
    chk("s6_pending", cfg_ready, 0);
    @(negedge clk);
    chk("s6_q", q, 0);
    chk("s6_ready", cfg_ready, 1);
    chk("s6_busy", busy, 0);
    rst_n = 1'b1; cfg_valid = 1'b0; c0 = cyc;
    wait_tick(t1); chk("s6_first_rise", t1 - c0, 5);
    wait_tick(t2); chk("s6_period", t2 - t1, 8);
    @(negedge clk); en = 1'b0;
    wait_q_low(t1);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
